// File: rtl/ex_mem_branch_stage.sv
// EX->MEM pipeline register with BNE/BLT resolution, one-cycle fetch redirect
// and squashing of the SHADOW younger instructions behind a taken branch.
module ex_mem_branch_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned SHADOW  = 2,
  parameter logic [4:0]  OPC_BNE = 5'b00010,
  parameter logic [4:0]  OPC_BLT = 5'b00110
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        in_opcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_target,
  input  logic [DATA_W-1:0] data_result,
  input  logic              isNotEqual,
  input  logic              isLessThan,
  input  logic              ctrl_stall,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wb,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              squash_active
);

  localparam int unsigned CNT_W = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;

  typedef enum logic {RUN, SQUASH} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept, is_branch, taken, redirect_set;

  assign accept    = in_valid & ~ctrl_stall;
  assign is_branch = (in_opcode == OPC_BNE) | (in_opcode == OPC_BLT);
  assign taken     = ((in_opcode == OPC_BNE) & isNotEqual) |
                     ((in_opcode == OPC_BLT) & isLessThan);

  assign in_ready      = ~ctrl_stall;
  assign squash_active = (state == SQUASH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    redirect_set = 1'b0;
    if (accept) begin
      unique case (state)
        RUN: begin
          if (taken) begin
            redirect_set = 1'b1;
            if (SHADOW > 0) begin
              state_next = SQUASH;
              cnt_next   = CNT_W'(SHADOW);
            end
          end
        end
        SQUASH: begin
          // Saturating decrement; leaving on the last slot means a taken
          // branch in that slot is dropped without a redirect.
          cnt_next = (cnt != '0) ? cnt - CNT_W'(1) : '0;
          if (cnt <= CNT_W'(1)) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_rd         <= '0;
      out_wb         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // The redirect pulse is not subject to the stall hold.
      redirect_valid <= redirect_set;
      if (redirect_set) redirect_pc <= in_target;
      if (!ctrl_stall) begin
        if (accept && state == RUN) begin
          out_valid  <= 1'b1;
          out_result <= data_result;
          out_rd     <= in_rd;
          out_wb     <= ~is_branch & (in_rd != '0);
        end else begin
          out_valid <= 1'b0;
          out_wb    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Scoreboard bench for ex_mem_branch_stage: SHADOW=2 instance plus a SHADOW=0
// instance sharing the same inputs.
module tb_ex_mem_branch_stage;

  localparam logic [4:0] ADD = 5'b00000;
  localparam logic [4:0] BNE = 5'b00010;
  localparam logic [4:0] BLT = 5'b00110;

  typedef struct {
    logic        v;
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ne;
    logic        lt;
    logic [31:0] tgt;
    logic        st;
  } stim_t;

  typedef struct {
    logic        ov;
    logic        wb;
    logic        rv;
    logic        sq;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] rpc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_target = '0;
  logic [31:0] data_result = '0;
  logic        isNotEqual = 1'b0;
  logic        isLessThan = 1'b0;
  logic        ctrl_stall = 1'b0;

  logic        in_ready, out_valid, out_wb, redirect_valid, squash_active;
  logic [31:0] out_result, redirect_pc;
  logic [4:0]  out_rd;
  logic        r0_ready, o0_valid, o0_wb, r0_valid, s0_active;
  logic [31:0] o0_result, r0_pc;
  logic [4:0]  o0_rd;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        exp_q[$];

  always #5 clock = ~clock;

  ex_mem_branch_stage #(.DATA_W(32), .REG_W(5), .SHADOW(2), .OPC_BNE(BNE), .OPC_BLT(BLT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_target(in_target), .data_result(data_result), .isNotEqual(isNotEqual),
    .isLessThan(isLessThan), .ctrl_stall(ctrl_stall), .in_ready(in_ready),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd), .out_wb(out_wb),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .squash_active(squash_active)
  );

  ex_mem_branch_stage #(.DATA_W(32), .REG_W(5), .SHADOW(0), .OPC_BNE(BNE), .OPC_BLT(BLT)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_target(in_target), .data_result(data_result), .isNotEqual(isNotEqual),
    .isLessThan(isLessThan), .ctrl_stall(ctrl_stall), .in_ready(r0_ready),
    .out_valid(o0_valid), .out_result(o0_result), .out_rd(o0_rd), .out_wb(o0_wb),
    .redirect_valid(r0_valid), .redirect_pc(r0_pc), .squash_active(s0_active)
  );

  function automatic stim_t S(logic v, logic [4:0] opc, logic [4:0] rd, logic [31:0] res,
                              logic ne, logic lt, logic [31:0] tgt, logic st);
    stim_t s;
    s.v = v; s.opc = opc; s.rd = rd; s.res = res; s.ne = ne; s.lt = lt; s.tgt = tgt; s.st = st;
    return s;
  endfunction

  function automatic exp_t E(logic ov, logic wb, logic rv, logic sq,
                             logic [31:0] res, logic [4:0] rd, logic [31:0] rpc);
    exp_t e;
    e.ov = ov; e.wb = wb; e.rv = rv; e.sq = sq; e.res = res; e.rd = rd; e.rpc = rpc;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    in_valid = s.v; in_opcode = s.opc; in_rd = s.rd; data_result = s.res;
    isNotEqual = s.ne; isLessThan = s.lt; in_target = s.tgt; ctrl_stall = s.st;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_wb, redirect_valid, squash_active, out_result, out_rd, redirect_pc} !== '0) begin
      miscompares++;
      $display("FAIL reset_initial outputs got v=%b wb=%b rv=%b sq=%b res=%h rd=%0d pc=%h want all 0",
               out_valid, out_wb, redirect_valid, squash_active, out_result, out_rd, redirect_pc);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    st.push_back(S(1, ADD, 1, 32'h11, 0, 0, 0, 0)); ex.push_back(E(1, 1, 0, 0, 32'h11, 1, 0));
    st.push_back(S(1, BNE, 0, 32'h0, 1, 0, 32'h80, 0)); ex.push_back(E(1, 0, 1, 1, 0, 0, 32'h80));
    st.push_back(S(1, ADD, 2, 32'h22, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(ex[i]);
      apply(st[i]);
      e = exp_q.pop_front();
      vectors++; if (out_valid !== e.ov) begin miscompares++; $display("FAIL reset_setup[%0d] out_valid got %b want %b", i, out_valid, e.ov); end
      vectors++; if (redirect_valid !== e.rv) begin miscompares++; $display("FAIL reset_setup[%0d] redirect_valid got %b want %b", i, redirect_valid, e.rv); end
      vectors++; if (squash_active !== e.sq) begin miscompares++; $display("FAIL reset_setup[%0d] squash_active got %b want %b", i, squash_active, e.sq); end
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_wb, redirect_valid, squash_active, out_result, out_rd, redirect_pc} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_squash outputs got v=%b wb=%b rv=%b sq=%b res=%h rd=%0d pc=%h want all 0",
               out_valid, out_wb, redirect_valid, squash_active, out_result, out_rd, redirect_pc);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.push_back(E(1, 1, 0, 0, 32'h12, 3, 0));
    apply(S(1, ADD, 3, 32'h12, 0, 0, 0, 0));
    e = exp_q.pop_front();
    vectors++; if (out_valid !== e.ov) begin miscompares++; $display("FAIL reset_after out_valid got %b want %b", out_valid, e.ov); end
    vectors++; if (out_wb !== e.wb) begin miscompares++; $display("FAIL reset_after out_wb got %b want %b", out_wb, e.wb); end
    vectors++; if (out_result !== e.res) begin miscompares++; $display("FAIL reset_after out_result got %h want %h", out_result, e.res); end
    vectors++; if (squash_active !== e.sq) begin miscompares++; $display("FAIL reset_after squash_active got %b want %b", squash_active, e.sq); end
  endtask

  // Shared body for the SHADOW=2 scenario tables; comparisons inline per task.
  task automatic test_basic;
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1, ADD, 5, 32'hDEADBEEF, 0, 0, 0, 0)); ex.push_back(E(1, 1, 0, 0, 32'hDEADBEEF, 5, 0));
    st.push_back(S(1, ADD, 0, 32'h55, 0, 0, 0, 0));       ex.push_back(E(1, 0, 0, 0, 32'h55, 0, 0));
    st.push_back(S(0, ADD, 7, 32'h66, 0, 0, 0, 0));       ex.push_back(E(0, 0, 0, 0, 0, 0, 0));
    st.push_back(S(1, BNE, 7, 32'h77, 0, 1, 32'h90, 0));  ex.push_back(E(1, 0, 0, 0, 0, 0, 0));
    st.push_back(S(1, ADD, 31, 32'h0BAD_F00D, 1, 1, 0, 0)); ex.push_back(E(1, 1, 0, 0, 32'h0BADF00D, 31, 0));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(ex[i]);
      apply(st[i]);
      e = exp_q.pop_front();
      vectors++; if (out_valid !== e.ov) begin miscompares++; $display("FAIL basic[%0d] out_valid got %b want %b", i, out_valid, e.ov); end
      vectors++; if (out_wb !== e.wb) begin miscompares++; $display("FAIL basic[%0d] out_wb got %b want %b", i, out_wb, e.wb); end
      vectors++; if (redirect_valid !== e.rv) begin miscompares++; $display("FAIL basic[%0d] redirect_valid got %b want %b", i, redirect_valid, e.rv); end
      vectors++; if (squash_active !== e.sq) begin miscompares++; $display("FAIL basic[%0d] squash_active got %b want %b", i, squash_active, e.sq); end
      if (e.wb) begin
        vectors++; if (out_result !== e.res) begin miscompares++; $display("FAIL basic[%0d] out_result got %h want %h", i, out_result, e.res); end
        vectors++; if (out_rd !== e.rd) begin miscompares++; $display("FAIL basic[%0d] out_rd got %0d want %0d", i, out_rd, e.rd); end
      end
    end
  endtask

  task automatic test_branch_squash;
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1, BNE, 0, 32'h0, 1, 0, 32'h40, 0));  ex.push_back(E(1, 0, 1, 1, 0, 0, 32'h40));
    st.push_back(S(0, ADD, 2, 32'h0, 0, 0, 0, 0));       ex.push_back(E(0, 0, 0, 1, 0, 0, 0));
    st.push_back(S(1, ADD, 2, 32'h21, 0, 0, 0, 0));      ex.push_back(E(0, 0, 0, 1, 0, 0, 0));
    st.push_back(S(1, BLT, 0, 32'h0, 0, 1, 32'h99, 0));  ex.push_back(E(0, 0, 0, 0, 0, 0, 0));
    st.push_back(S(1, ADD, 4, 32'h1234, 0, 0, 0, 0));    ex.push_back(E(1, 1, 0, 0, 32'h1234, 4, 0));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(ex[i]);
      apply(st[i]);
      e = exp_q.pop_front();
      vectors++; if (out_valid !== e.ov) begin miscompares++; $display("FAIL squash[%0d] out_valid got %b want %b", i, out_valid, e.ov); end
      vectors++; if (out_wb !== e.wb) begin miscompares++; $display("FAIL squash[%0d] out_wb got %b want %b", i, out_wb, e.wb); end
      vectors++; if (redirect_valid !== e.rv) begin miscompares++; $display("FAIL squash[%0d] redirect_valid got %b want %b", i, redirect_valid, e.rv); end
      vectors++; if (squash_active !== e.sq) begin miscompares++; $display("FAIL squash[%0d] squash_active got %b want %b", i, squash_active, e.sq); end
      if (e.rv) begin
        vectors++; if (redirect_pc !== e.rpc) begin miscompares++; $display("FAIL squash[%0d] redirect_pc got %h want %h", i, redirect_pc, e.rpc); end
      end
      if (e.wb) begin
        vectors++; if (out_result !== e.res) begin miscompares++; $display("FAIL squash[%0d] out_result got %h want %h", i, out_result, e.res); end
      end
    end
  endtask

  task automatic test_blt;
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1, BLT, 6, 32'h5, 1, 0, 32'h44, 0)); ex.push_back(E(1, 0, 0, 0, 0, 0, 0));
    st.push_back(S(1, ADD, 6, 32'h66, 0, 0, 0, 0));     ex.push_back(E(1, 1, 0, 0, 32'h66, 6, 0));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(ex[i]);
      apply(st[i]);
      e = exp_q.pop_front();
      vectors++; if (out_valid !== e.ov) begin miscompares++; $display("FAIL blt[%0d] out_valid got %b want %b", i, out_valid, e.ov); end
      vectors++; if (out_wb !== e.wb) begin miscompares++; $display("FAIL blt[%0d] out_wb got %b want %b", i, out_wb, e.wb); end
      vectors++; if (redirect_valid !== e.rv) begin miscompares++; $display("FAIL blt[%0d] redirect_valid got %b want %b", i, redirect_valid, e.rv); end
      vectors++; if (squash_active !== e.sq) begin miscompares++; $display("FAIL blt[%0d] squash_active got %b want %b", i, squash_active, e.sq); end
    end
  endtask

  task automatic test_blt_shadow0;
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1, BLT, 0, 32'h0, 0, 1, 32'h7C, 0)); ex.push_back(E(1, 0, 1, 0, 0, 0, 32'h7C));
    st.push_back(S(1, ADD, 9, 32'h99, 0, 0, 0, 0));     ex.push_back(E(1, 1, 0, 0, 32'h99, 9, 0));
    st.push_back(S(1, ADD, 10, 32'hAA, 0, 0, 0, 0));    ex.push_back(E(1, 1, 0, 0, 32'hAA, 10, 0));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(ex[i]);
      apply(st[i]);
      e = exp_q.pop_front();
      vectors++; if (o0_valid !== e.ov) begin miscompares++; $display("FAIL shadow0[%0d] out_valid got %b want %b", i, o0_valid, e.ov); end
      vectors++; if (o0_wb !== e.wb) begin miscompares++; $display("FAIL shadow0[%0d] out_wb got %b want %b", i, o0_wb, e.wb); end
      vectors++; if (r0_valid !== e.rv) begin miscompares++; $display("FAIL shadow0[%0d] redirect_valid got %b want %b", i, r0_valid, e.rv); end
      vectors++; if (s0_active !== e.sq) begin miscompares++; $display("FAIL shadow0[%0d] squash_active got %b want %b", i, s0_active, e.sq); end
      if (e.rv) begin
        vectors++; if (r0_pc !== e.rpc) begin miscompares++; $display("FAIL shadow0[%0d] redirect_pc got %h want %h", i, r0_pc, e.rpc); end
      end
      if (e.wb) begin
        vectors++; if (o0_rd !== e.rd) begin miscompares++; $display("FAIL shadow0[%0d] out_rd got %0d want %0d", i, o0_rd, e.rd); end
      end
    end
  endtask

  task automatic test_stall;
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1, ADD, 1, 32'hA1, 0, 0, 0, 0)); ex.push_back(E(1, 1, 0, 0, 32'hA1, 1, 0));
    for (int k = 0; k < 3; k++) begin
      st.push_back(S(1, ADD, 2, 32'hB2, 0, 0, 0, 1)); ex.push_back(E(1, 1, 0, 0, 32'hA1, 1, 0));
    end
    st.push_back(S(1, ADD, 2, 32'hB2, 0, 0, 0, 0)); ex.push_back(E(1, 1, 0, 0, 32'hB2, 2, 0));
    st.push_back(S(1, BNE, 0, 32'h0, 1, 0, 32'h20, 0)); ex.push_back(E(1, 0, 1, 1, 0, 0, 32'h20));
    for (int k = 0; k < 3; k++) begin
      st.push_back(S(1, BNE, 0, 32'h0, 1, 0, 32'h30, 1)); ex.push_back(E(1, 0, 0, 1, 0, 0, 0));
    end
    st.push_back(S(1, ADD, 3, 32'hC3, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 1, 0, 0, 0));
    st.push_back(S(1, ADD, 3, 32'hC3, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0, 0, 0, 0));
    st.push_back(S(1, ADD, 3, 32'hC3, 0, 0, 0, 0)); ex.push_back(E(1, 1, 0, 0, 32'hC3, 3, 0));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(ex[i]);
      apply(st[i]);
      e = exp_q.pop_front();
      vectors++; if (in_ready !== !st[i].st) begin miscompares++; $display("FAIL stall[%0d] in_ready got %b want %b", i, in_ready, !st[i].st); end
      vectors++; if (out_valid !== e.ov) begin miscompares++; $display("FAIL stall[%0d] out_valid got %b want %b", i, out_valid, e.ov); end
      vectors++; if (out_wb !== e.wb) begin miscompares++; $display("FAIL stall[%0d] out_wb got %b want %b", i, out_wb, e.wb); end
      vectors++; if (redirect_valid !== e.rv) begin miscompares++; $display("FAIL stall[%0d] redirect_valid got %b want %b", i, redirect_valid, e.rv); end
      vectors++; if (squash_active !== e.sq) begin miscompares++; $display("FAIL stall[%0d] squash_active got %b want %b", i, squash_active, e.sq); end
      if (e.wb) begin
        vectors++; if (out_result !== e.res) begin miscompares++; $display("FAIL stall[%0d] out_result got %h want %h", i, out_result, e.res); end
        vectors++; if (out_rd !== e.rd) begin miscompares++; $display("FAIL stall[%0d] out_rd got %0d want %0d", i, out_rd, e.rd); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_branch_squash;
    test_blt;
    test_blt_shadow0;
    test_stall;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain pending got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
